// File: rtl/mips_exec_mem.sv
// Single-cycle MIPS execute/memory slice: control decode, operand muxing, 32-bit ALU, data RAM + LED/switch/tube registers.
// Everything is combinational from the inputs except RAM/LED/tube writes, which land on the rising clock edge.
module mips_exec_mem #(
  parameter int RAM_WORDS = 512
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instruction,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic        i_irq,
  input  logic [7:0]  i_switch,
  output logic [2:0]  o_pc_src,
  output logic [1:0]  o_reg_dst,
  output logic        o_reg_write,
  output logic [31:0] o_alu_out,
  output logic [31:0] o_con_ba,
  output logic [31:0] o_wb_data,
  output logic [7:0]  o_led,
  output logic [17:0] o_tube
);
  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  localparam logic [5:0] ALU_ADD = 6'b000000, ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000, ALU_OR  = 6'b011110, ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001, ALU_A   = 6'b011010;
  localparam logic [5:0] ALU_SLL = 6'b100000, ALU_SRL = 6'b100001, ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011, ALU_NEQ = 6'b110001, ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101, ALU_LTZ = 6'b111011, ALU_GTZ = 6'b111111;

  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;

  localparam logic [31:0] ADDR_LED  = 32'h4000_000C;
  localparam logic [31:0] ADDR_SW   = 32'h4000_0010;
  localparam logic [31:0] ADDR_TUBE = 32'h4000_0014;

  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_shamt;
  logic [15:0] w_imm;
  logic        w_unused;

  logic [2:0]  w_pc_src;
  logic [1:0]  w_reg_dst, w_mem_to_reg;
  logic        w_reg_write, w_mem_rd, w_mem_wr, w_sign, w_ext_op;
  logic        w_alu_src1, w_alu_src2, w_lu_op, w_undef;
  logic [5:0]  w_alu_fun;

  logic [31:0] w_imm_ext, w_lu_out, w_alu_a, w_alu_b, w_alu_out;
  logic [31:0] w_pc_plus4, w_mem_rdata;
  logic        w_ram_hit;
  logic [AW-1:0] w_ram_idx;

  logic [31:0] r_ram [RAM_WORDS];
  logic [7:0]  r_led;
  logic [17:0] r_tube;

  assign w_opcode = i_instruction[31:26];
  assign w_funct  = i_instruction[5:0];
  assign w_shamt  = i_instruction[10:6];
  assign w_imm    = i_instruction[15:0];
  // Register numbers are resolved by the top level; only their data arrives here.
  assign w_unused = ^i_instruction[25:16];

  always_comb begin
    w_pc_src     = 3'b000;
    w_reg_dst    = 2'b00;
    w_reg_write  = 1'b0;
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    w_sign       = 1'b1;
    w_ext_op     = 1'b1;
    w_alu_src1   = 1'b0;
    w_alu_src2   = 1'b0;
    w_lu_op      = 1'b0;
    w_alu_fun    = ALU_ADD;
    w_mem_to_reg = WB_ALU;
    w_undef      = 1'b0;
    case (w_opcode)
      6'h00: begin
        w_reg_dst   = 2'b01;
        w_reg_write = 1'b1;
        case (w_funct)
          6'h20: w_alu_fun = ALU_ADD;
          6'h21: begin w_alu_fun = ALU_ADD; w_sign = 1'b0; end
          6'h22: w_alu_fun = ALU_SUB;
          6'h23: begin w_alu_fun = ALU_SUB; w_sign = 1'b0; end
          6'h24: w_alu_fun = ALU_AND;
          6'h25: w_alu_fun = ALU_OR;
          6'h26: w_alu_fun = ALU_XOR;
          6'h27: w_alu_fun = ALU_NOR;
          6'h2A: w_alu_fun = ALU_LT;
          6'h2B: begin w_alu_fun = ALU_LT; w_sign = 1'b0; end
          6'h00: begin w_alu_fun = ALU_SLL; w_alu_src1 = 1'b1; end
          6'h02: begin w_alu_fun = ALU_SRL; w_alu_src1 = 1'b1; end
          6'h03: begin w_alu_fun = ALU_SRA; w_alu_src1 = 1'b1; end
          6'h08: begin w_pc_src = 3'b011; w_reg_write = 1'b0; w_reg_dst = 2'b00; end
          6'h09: begin w_pc_src = 3'b011; w_mem_to_reg = WB_PC4; end
          default: begin w_undef = 1'b1; w_reg_write = 1'b0; w_reg_dst = 2'b00; end
        endcase
      end
      6'h23: begin w_reg_write = 1'b1; w_alu_src2 = 1'b1; w_mem_rd = 1'b1; w_mem_to_reg = WB_MEM; end
      6'h2B: begin w_alu_src2 = 1'b1; w_mem_wr = 1'b1; end
      6'h0F: begin w_reg_write = 1'b1; w_alu_src2 = 1'b1; w_lu_op = 1'b1; end
      6'h08: begin w_reg_write = 1'b1; w_alu_src2 = 1'b1; end
      6'h09: begin w_reg_write = 1'b1; w_alu_src2 = 1'b1; w_sign = 1'b0; end
      6'h0C: begin w_reg_write = 1'b1; w_alu_src2 = 1'b1; w_ext_op = 1'b0; w_alu_fun = ALU_AND; end
      6'h0A: begin w_reg_write = 1'b1; w_alu_src2 = 1'b1; w_alu_fun = ALU_LT; end
      6'h0B: begin w_reg_write = 1'b1; w_alu_src2 = 1'b1; w_alu_fun = ALU_LT; w_sign = 1'b0; end
      6'h04: begin w_pc_src = 3'b001; w_alu_fun = ALU_EQ; end
      6'h05: begin w_pc_src = 3'b001; w_alu_fun = ALU_NEQ; end
      6'h06: begin w_pc_src = 3'b001; w_alu_fun = ALU_LEZ; end
      6'h07: begin w_pc_src = 3'b001; w_alu_fun = ALU_GTZ; end
      6'h02: w_pc_src = 3'b010;
      6'h03: begin w_pc_src = 3'b010; w_reg_write = 1'b1; w_reg_dst = 2'b10; w_mem_to_reg = WB_PC4; end
      default: w_undef = 1'b1;
    endcase
    // Traps only fire in user mode; interrupt outranks an undefined instruction.
    if (!i_pc[31] && (i_irq || w_undef)) begin
      w_pc_src     = i_irq ? 3'b100 : 3'b101;
      w_reg_write  = 1'b1;
      w_reg_dst    = 2'b11;
      w_mem_to_reg = WB_PC4;
      w_mem_rd     = 1'b0;
      w_mem_wr     = 1'b0;
    end
  end

  assign w_imm_ext = w_ext_op ? {{16{w_imm[15]}}, w_imm} : {16'b0, w_imm};
  assign w_lu_out  = w_lu_op ? {w_imm, 16'b0} : w_imm_ext;
  assign w_alu_a   = w_alu_src1 ? {27'b0, w_shamt} : i_rs_data;
  assign w_alu_b   = w_alu_src2 ? w_lu_out : i_rt_data;

  always_comb begin
    w_alu_out = 32'b0;
    case (w_alu_fun)
      ALU_ADD: w_alu_out = w_alu_a + w_alu_b;
      ALU_SUB: w_alu_out = w_alu_a - w_alu_b;
      ALU_AND: w_alu_out = w_alu_a & w_alu_b;
      ALU_OR:  w_alu_out = w_alu_a | w_alu_b;
      ALU_XOR: w_alu_out = w_alu_a ^ w_alu_b;
      ALU_NOR: w_alu_out = ~(w_alu_a | w_alu_b);
      ALU_A:   w_alu_out = w_alu_a;
      ALU_SLL: w_alu_out = w_alu_b << w_alu_a[4:0];
      ALU_SRL: w_alu_out = w_alu_b >> w_alu_a[4:0];
      ALU_SRA: w_alu_out = $signed(w_alu_b) >>> w_alu_a[4:0];
      ALU_EQ:  w_alu_out = {31'b0, w_alu_a == w_alu_b};
      ALU_NEQ: w_alu_out = {31'b0, w_alu_a != w_alu_b};
      ALU_LT:  w_alu_out = {31'b0, w_sign ? ($signed(w_alu_a) < $signed(w_alu_b)) : (w_alu_a < w_alu_b)};
      ALU_LEZ: w_alu_out = {31'b0, w_alu_a[31] || (w_alu_a == 32'b0)};
      ALU_LTZ: w_alu_out = {31'b0, w_alu_a[31]};
      ALU_GTZ: w_alu_out = {31'b0, !w_alu_a[31] && (w_alu_a != 32'b0)};
      default: w_alu_out = 32'b0;
    endcase
  end

  assign w_pc_plus4 = {i_pc[31], i_pc[30:0] + 31'd4};
  assign w_ram_hit  = (w_alu_out[1:0] == 2'b00) && ({2'b00, w_alu_out[31:2]} < 32'(RAM_WORDS));
  assign w_ram_idx  = w_alu_out[AW+1:2];

  always_comb begin
    w_mem_rdata = 32'b0;
    if (w_mem_rd) begin
      if (w_ram_hit)                    w_mem_rdata = r_ram[w_ram_idx];
      else if (w_alu_out == ADDR_LED)   w_mem_rdata = {24'b0, r_led};
      else if (w_alu_out == ADDR_SW)    w_mem_rdata = {24'b0, i_switch};
      else if (w_alu_out == ADDR_TUBE)  w_mem_rdata = {14'b0, r_tube};
    end
  end

  // RAM has no reset so its contents survive a core reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_mem_wr && w_ram_hit) r_ram[w_ram_idx] <= i_rt_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_led  <= 8'b0;
      r_tube <= 18'b0;
    end else if (w_mem_wr) begin
      if (w_alu_out == ADDR_LED)  r_led  <= i_rt_data[7:0];
      if (w_alu_out == ADDR_TUBE) r_tube <= i_rt_data[17:0];
    end
  end

  always_comb begin
    case (w_mem_to_reg)
      WB_MEM:  o_wb_data = w_mem_rdata;
      WB_PC4:  o_wb_data = w_pc_plus4;
      default: o_wb_data = w_alu_out;
    endcase
  end

  assign o_pc_src    = w_pc_src;
  assign o_reg_dst   = w_reg_dst;
  assign o_reg_write = w_reg_write;
  assign o_alu_out   = w_alu_out;
  assign o_con_ba    = {{14{w_imm[15]}}, w_imm, 2'b00} + i_pc + 32'd4;
  assign o_led       = r_led;
  assign o_tube      = r_tube;
endmodule

// File: tb/tb_mips_exec_mem.sv
// Self-checking bench for mips_exec_mem: directed cases plus randomized operands against a mnemonic-level model.
module tb_mips_exec_mem;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction, pc, rs_data, rt_data;
  logic        irq;
  logic [7:0]  sw;
  logic [2:0]  pc_src;
  logic [1:0]  reg_dst;
  logic        reg_write;
  logic [31:0] alu_out, con_ba, wb_data;
  logic [7:0]  led;
  logic [17:0] tube;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] r_functs [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
  logic [5:0] i_ops [6] = '{6'h08, 6'h09, 6'h0C, 6'h0A, 6'h0B, 6'h0F};

  mips_exec_mem #(.RAM_WORDS(512)) dut (
    .i_clk(clk), .i_reset(reset), .i_instruction(instruction), .i_pc(pc),
    .i_rs_data(rs_data), .i_rt_data(rt_data), .i_irq(irq), .i_switch(sw),
    .o_pc_src(pc_src), .o_reg_dst(reg_dst), .o_reg_write(reg_write),
    .o_alu_out(alu_out), .o_con_ba(con_ba), .o_wb_data(wb_data),
    .o_led(led), .o_tube(tube)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] sh);
    return {6'h00, 5'd1, 5'd2, 5'd3, sh, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Architectural result of each R-type mnemonic.
  function automatic logic [31:0] ref_r(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    case (f)
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B: return (a < b) ? 32'd1 : 32'd0;
      6'h00: return b << sh;
      6'h02: return b >> sh;
      6'h03: return 32'($signed(b) >>> sh);
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  function automatic logic [31:0] ref_i(input logic [5:0] op, input logic [31:0] a, input logic [15:0] imm);
    case (op)
      6'h08, 6'h09: return a + sx(imm);
      6'h0C: return a & {16'h0, imm};
      6'h0A: return ($signed(a) < $signed(sx(imm))) ? 32'd1 : 32'd0;
      6'h0B: return (a < sx(imm)) ? 32'd1 : 32'd0;
      6'h0F: return {imm, 16'h0};
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  function automatic logic ref_br(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'h04: return a == b;
      6'h05: return a != b;
      6'h06: return $signed(a) <= 0;
      default: return $signed(a) > 0;
    endcase
  endfunction

  task automatic do_sw(input logic [31:0] base, input logic [15:0] imm, input logic [31:0] data);
    instruction = itype(6'h2B, imm);
    rs_data = base;
    rt_data = data;
    @(posedge clk);
    #1;
    instruction = 32'h0;
  endtask

  task automatic drive_lw(input logic [31:0] base, input logic [15:0] imm);
    instruction = itype(6'h23, imm);
    rs_data = base;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (led !== 8'h0) begin n_fail++; $display("FAIL reset_led: got %h expected 00", led); end
    n_checks++; if (tube !== 18'h0) begin n_fail++; $display("FAIL reset_tube: got %h expected 00000", tube); end
    reset = 1'b0;
  endtask

  task automatic test_rtype;
    logic [31:0] a, b, exp;
    logic [5:0] f;
    logic [4:0] sh;
    instruction = rtype(6'h20, 5'd0); rs_data = 32'd5; rt_data = 32'd7; #1;
    n_checks++; if (alu_out !== 32'd12) begin n_fail++; $display("FAIL add_alu: got %h expected 0000000c", alu_out); end
    n_checks++; if ({pc_src, reg_dst, reg_write} !== {3'b000, 2'b01, 1'b1})
      begin n_fail++; $display("FAIL add_ctrl: got %b/%b/%b expected 000/01/1", pc_src, reg_dst, reg_write); end
    instruction = rtype(6'h2A, 5'd0); rs_data = 32'hFFFFFFFF; rt_data = 32'd1; #1;
    n_checks++; if (alu_out !== 32'd1) begin n_fail++; $display("FAIL slt_neg: got %h expected 00000001", alu_out); end
    instruction = rtype(6'h2B, 5'd0); #1;
    n_checks++; if (alu_out !== 32'd0) begin n_fail++; $display("FAIL sltu_big: got %h expected 00000000", alu_out); end
    for (int i = 0; i < 40; i++) begin
      f = r_functs[$urandom_range(0, 12)];
      a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom; sh = 5'($urandom);
      instruction = rtype(f, sh); rs_data = a; rt_data = b; #1;
      exp = ref_r(f, a, b, sh);
      n_checks++; if (wb_data !== exp || reg_write !== 1'b1 || reg_dst !== 2'b01) begin
        n_fail++; $display("FAIL rtype_rand f=%h a=%h b=%h sh=%0d: got %h/%b/%b expected %h/1/01", f, a, b, sh, wb_data, reg_write, reg_dst, exp);
      end
    end
  endtask

  task automatic test_shift;
    instruction = rtype(6'h03, 5'd4); rs_data = 32'h0; rt_data = 32'h80000000; #1;
    n_checks++; if (alu_out !== 32'hF8000000) begin n_fail++; $display("FAIL sra4: got %h expected f8000000", alu_out); end
    instruction = rtype(6'h02, 5'd4); #1;
    n_checks++; if (alu_out !== 32'h08000000) begin n_fail++; $display("FAIL srl4: got %h expected 08000000", alu_out); end
    instruction = rtype(6'h00, 5'd31); rt_data = 32'h00000003; rs_data = 32'hFFFFFFFF; #1;
    n_checks++; if (alu_out !== 32'h80000000) begin n_fail++; $display("FAIL sll31: got %h expected 80000000", alu_out); end
  endtask

  task automatic test_imm;
    logic [31:0] a, exp;
    logic [15:0] imm;
    logic [5:0] op;
    for (int i = 0; i < 40; i++) begin
      op = i_ops[$urandom_range(0, 5)];
      imm = 16'($urandom);
      a = (op == 6'h0F) ? 32'h0 : $urandom;
      instruction = itype(op, imm); rs_data = a; rt_data = $urandom; #1;
      exp = ref_i(op, a, imm);
      n_checks++; if (wb_data !== exp || reg_write !== 1'b1 || reg_dst !== 2'b00 || pc_src !== 3'b000) begin
        n_fail++; $display("FAIL imm_rand op=%h a=%h imm=%h: got %h/%b/%b expected %h/1/00", op, a, imm, wb_data, reg_write, reg_dst, exp);
      end
    end
  endtask

  task automatic test_branch;
    logic [31:0] a, b, exp_ba;
    logic [15:0] imm;
    logic [5:0] op;
    instruction = itype(6'h04, 16'd3); pc = 32'h100; rs_data = 32'h1234; rt_data = 32'h1234; #1;
    n_checks++; if (alu_out !== 32'd1) begin n_fail++; $display("FAIL beq_taken: got %h expected 00000001", alu_out); end
    n_checks++; if (con_ba !== 32'h110) begin n_fail++; $display("FAIL beq_target: got %h expected 00000110", con_ba); end
    for (int i = 0; i < 40; i++) begin
      op = 6'($urandom_range(4, 7));
      imm = 16'($urandom);
      case ($urandom_range(0, 3))
        0: a = 32'h0;
        1: a = 32'($signed($urandom_range(0, 4)) - 2);
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      pc = {1'b0, 29'($urandom), 2'b00};
      instruction = itype(op, imm); rs_data = a; rt_data = b; #1;
      exp_ba = pc + 32'd4 + (sx(imm) << 2);
      n_checks++; if (alu_out !== {31'b0, ref_br(op, a, b)} || con_ba !== exp_ba || pc_src !== 3'b001 || reg_write !== 1'b0) begin
        n_fail++; $display("FAIL branch_rand op=%h a=%h b=%h: got %h/%h/%b expected %h/%h/001", op, a, b, alu_out, con_ba, pc_src, {31'b0, ref_br(op, a, b)}, exp_ba);
      end
    end
    pc = 32'h0;
  endtask

  task automatic test_jump;
    instruction = {6'h02, 26'h0123456}; pc = 32'h40; #1;
    n_checks++; if (pc_src !== 3'b010 || reg_write !== 1'b0) begin n_fail++; $display("FAIL j_ctrl: got %b/%b expected 010/0", pc_src, reg_write); end
    instruction = {6'h03, 26'h0123456}; pc = 32'h80000100; #1;
    n_checks++; if ({pc_src, reg_dst, reg_write} !== {3'b010, 2'b10, 1'b1} || wb_data !== 32'h80000104)
      begin n_fail++; $display("FAIL jal_kernel: got %b/%b/%b wb=%h expected 010/10/1 wb=80000104", pc_src, reg_dst, reg_write, wb_data); end
    pc = 32'h7FFFFFFC; #1;
    n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL jal_wrap: got %h expected 00000000", wb_data); end
    instruction = rtype(6'h08, 5'd0); pc = 32'h40; #1;
    n_checks++; if (pc_src !== 3'b011 || reg_write !== 1'b0) begin n_fail++; $display("FAIL jr_ctrl: got %b/%b expected 011/0", pc_src, reg_write); end
    instruction = rtype(6'h09, 5'd0); #1;
    n_checks++; if ({pc_src, reg_dst, reg_write} !== {3'b011, 2'b01, 1'b1} || wb_data !== 32'h44)
      begin n_fail++; $display("FAIL jalr_ctrl: got %b/%b/%b wb=%h expected 011/01/1 wb=00000044", pc_src, reg_dst, reg_write, wb_data); end
    pc = 32'h0;
  endtask

  task automatic test_mem;
    logic [31:0] mdl [int];
    int idx;
    logic [31:0] v;
    do_sw(32'h10, 16'h0, 32'hDEADBEEF);
    drive_lw(32'h10, 16'h0);
    n_checks++; if (wb_data !== 32'hDEADBEEF || reg_dst !== 2'b00 || reg_write !== 1'b1)
      begin n_fail++; $display("FAIL lw_0x10: got %h/%b expected deadbeef/00", wb_data, reg_dst); end
    for (int i = 0; i < 12; i++) begin
      idx = $urandom_range(16, 511);
      v = $urandom;
      mdl[idx] = v;
      do_sw(32'(idx * 4 + 8), 16'hFFF8, v);
    end
    foreach (mdl[k]) begin
      drive_lw(32'(k * 4), 16'h0);
      n_checks++; if (wb_data !== mdl[k]) begin n_fail++; $display("FAIL ram_rand word %0d: got %h expected %h", k, wb_data, mdl[k]); end
    end
    do_sw(32'h0, 16'h0, 32'h11111111);
    do_sw(32'h800, 16'h0, 32'h22222222);
    drive_lw(32'h0, 16'h0);
    n_checks++; if (wb_data !== 32'h11111111) begin n_fail++; $display("FAIL ram_no_alias: got %h expected 11111111", wb_data); end
    drive_lw(32'h800, 16'h0);
    n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL ram_oob_read: got %h expected 00000000", wb_data); end
    instruction = 32'h0;
  endtask

  task automatic test_mmio;
    logic [7:0] s;
    do_sw(32'h40000000, 16'h000C, 32'h123456A5);
    n_checks++; if (led !== 8'hA5) begin n_fail++; $display("FAIL led_write: got %h expected a5", led); end
    do_sw(32'h40000000, 16'h0014, 32'hFFFFFFFF);
    n_checks++; if (tube !== 18'h3FFFF) begin n_fail++; $display("FAIL tube_write: got %h expected 3ffff", tube); end
    drive_lw(32'h40000000, 16'h000C);
    n_checks++; if (wb_data !== 32'hA5) begin n_fail++; $display("FAIL led_read: got %h expected 000000a5", wb_data); end
    drive_lw(32'h40000000, 16'h0014);
    n_checks++; if (wb_data !== 32'h3FFFF) begin n_fail++; $display("FAIL tube_read: got %h expected 0003ffff", wb_data); end
    s = 8'($urandom); sw = s;
    drive_lw(32'h40000000, 16'h0010);
    n_checks++; if (wb_data !== {24'h0, s}) begin n_fail++; $display("FAIL switch_read: got %h expected %h", wb_data, {24'h0, s}); end
    drive_lw(32'h40000000, 16'h0018);
    n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 00000000", wb_data); end
    instruction = itype(6'h2B, 16'h000C); rs_data = 32'h40000000; rt_data = 32'h77;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; instruction = 32'h0;
    n_checks++; if (led !== 8'h0 || tube !== 18'h0) begin n_fail++; $display("FAIL reset_clears: got led=%h tube=%h expected 00/00000", led, tube); end
    drive_lw(32'h10, 16'h0);
    n_checks++; if (wb_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_keeps_on_reset: got %h expected deadbeef", wb_data); end
    instruction = 32'h0;
  endtask

  task automatic test_irq;
    instruction = rtype(6'h20, 5'd0); rs_data = 32'd5; rt_data = 32'd7; pc = 32'h40; irq = 1'b1; #1;
    n_checks++; if ({pc_src, reg_dst, reg_write} !== {3'b100, 2'b11, 1'b1} || wb_data !== 32'h44)
      begin n_fail++; $display("FAIL irq_user: got %b/%b/%b wb=%h expected 100/11/1 wb=00000044", pc_src, reg_dst, reg_write, wb_data); end
    pc = 32'h80000040; #1;
    n_checks++; if (pc_src !== 3'b000 || reg_dst !== 2'b01 || wb_data !== 32'd12)
      begin n_fail++; $display("FAIL irq_kernel: got %b/%b wb=%h expected 000/01 wb=0000000c", pc_src, reg_dst, wb_data); end
    irq = 1'b0; pc = 32'h0;
    do_sw(32'h20, 16'h0, 32'h12345678);
    pc = 32'h40; irq = 1'b1;
    do_sw(32'h20, 16'h0, 32'hCAFEF00D);
    irq = 1'b0; pc = 32'h0;
    drive_lw(32'h20, 16'h0);
    n_checks++; if (wb_data !== 32'h12345678) begin n_fail++; $display("FAIL irq_blocks_store: got %h expected 12345678", wb_data); end
    instruction = 32'h0;
  endtask

  task automatic test_undef;
    instruction = itype(6'h3F, 16'h0); pc = 32'h40; #1;
    n_checks++; if ({pc_src, reg_dst, reg_write} !== {3'b101, 2'b11, 1'b1} || wb_data !== 32'h44)
      begin n_fail++; $display("FAIL undef_op: got %b/%b/%b wb=%h expected 101/11/1 wb=00000044", pc_src, reg_dst, reg_write, wb_data); end
    instruction = rtype(6'h01, 5'd0); #1;
    n_checks++; if (pc_src !== 3'b101 || reg_dst !== 2'b11) begin n_fail++; $display("FAIL undef_funct: got %b/%b expected 101/11", pc_src, reg_dst); end
    instruction = itype(6'h3F, 16'h0); pc = 32'h80000040; #1;
    n_checks++; if (pc_src !== 3'b000 || reg_write !== 1'b0) begin n_fail++; $display("FAIL undef_kernel_nop: got %b/%b expected 000/0", pc_src, reg_write); end
    pc = 32'h0; instruction = 32'h0;
  endtask

  initial begin
    reset = 1'b1; instruction = 32'h0; pc = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
    irq = 1'b0; sw = 8'h0;
    test_reset();
    test_rtype();
    test_shift();
    test_imm();
    test_branch();
    test_jump();
    test_mem();
    test_mmio();
    test_irq();
    test_undef();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
